lsq_mem_scheduler: RTL and testbench

Selects which load/store queue entry accesses the single data-memory port each transaction, and sequences that access through a req/gnt/rvalid handshake.
- Sits between the LSQ entry array and the data-memory port.
- Loads issue out of order, subject to conservative address disambiguation; stores drain in order, only after commit.
- Reports completion by entry index so the LSQ can write back load data and retire stores.

---
 rtl/lsq_pkg.sv | 20 ++
 rtl/lsq_age_picker.sv | 29 ++
 rtl/lsq_mem_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_lsq_mem_scheduler.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsq_pkg.sv
// Shared types and constants for the LSQ memory-port scheduler.
package lsq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } lsq_sched_state_e;

    localparam int LSQ_DEFAULT_ENTRIES = 16;
    localparam int LSQ_IDX_W           = $clog2(LSQ_DEFAULT_ENTRIES);

    // Entry index for the default 16-deep LSQ configuration.
    typedef logic [LSQ_IDX_W-1:0] lsq_idx_t;

    // Low address bits below the word granule; ignored for disambiguation.
    localparam int WORD_OFFSET = 2;

endpackage

// File: rtl/lsq_age_picker.sv
// Combinational oldest-first picker: returns the requesting entry of least
// age relative to head_ptr.
module lsq_age_picker #(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic [NUM_ENTRIES-1:0] req,
    input  logic [IDX_W-1:0]       head_ptr,
    output logic                   found,
    output logic [IDX_W-1:0]       idx
);

    logic [IDX_W-1:0] cand;

    // Scan youngest to oldest so the last hit is the oldest; index wraps mod depth.
    always_comb begin
        found = 1'b0;
        idx   = head_ptr;
        cand  = '0;
        for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
            cand = head_ptr + IDX_W'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/lsq_mem_scheduler.sv
// Chooses the LSQ entry that owns the data-memory port and runs its
// req/gnt/rvalid handshake; reports load/store completion by entry index.
//
//  state | meaning
//  IDLE  | pick the oldest eligible entry and latch its request
//  REQ   | mem_req held with stable we/addr/wdata until mem_gnt
//  RESP  | load granted, waiting for mem_rvalid
//  DRAIN | flushed load granted, swallow its mem_rvalid
module lsq_mem_scheduler
    import lsq_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [IDX_W-1:0]                  head_ptr,
    input  logic [NUM_ENTRIES-1:0]            entry_valid,
    input  logic [NUM_ENTRIES-1:0]            entry_is_load,
    input  logic [NUM_ENTRIES-1:0]            entry_addr_valid,
    input  logic [NUM_ENTRIES-1:0]            entry_data_valid,
    input  logic [NUM_ENTRIES-1:0]            entry_committed,
    input  logic [NUM_ENTRIES*ADDR_WIDTH-1:0] entry_addr,
    input  logic [NUM_ENTRIES*DATA_WIDTH-1:0] entry_data,
    input  logic                              flush,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    input  logic                              mem_gnt,
    input  logic                              mem_rvalid,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    output logic                              load_done,
    output logic [IDX_W-1:0]                  load_done_idx,
    output logic [DATA_WIDTH-1:0]             load_done_data,
    output logic                              store_done,
    output logic [IDX_W-1:0]                  store_done_idx
);

    lsq_sched_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0]  addr_arr [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  data_arr [NUM_ENTRIES];
    logic [IDX_W-1:0]       age      [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] issued_q, issued_d;
    logic [NUM_ENTRIES-1:0] st_cmpl_q, st_cmpl_d;
    logic [NUM_ENTRIES-1:0] st_live, st_cand, ld_elig;

    logic                   st_found, ld_found, st_ok;
    logic [IDX_W-1:0]       st_idx, ld_idx, st_age, ld_age;
    logic                   sel_found, sel_we;
    logic [IDX_W-1:0]       sel_idx;
    logic                   take, ld_fire, st_fire;

    logic [IDX_W-1:0]       idx_q;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            addr_arr[i] = entry_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            data_arr[i] = entry_data[i*DATA_WIDTH +: DATA_WIDTH];
            age[i]      = IDX_W'(i) - head_ptr;
        end
    end

    // A store stays live for ordering until it has been granted.
    assign st_live = entry_valid & ~entry_is_load & ~st_cmpl_q;
    assign st_cand = st_live & ~issued_q;

    always_comb begin
        logic blocked;
        ld_elig = '0;
        blocked = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (st_live[j] && (age[j] < age[i]) &&
                    (!entry_addr_valid[j] ||
                     addr_arr[j][ADDR_WIDTH-1:WORD_OFFSET] == addr_arr[i][ADDR_WIDTH-1:WORD_OFFSET]))
                    blocked = 1'b1;
            end
            ld_elig[i] = entry_valid[i] & entry_is_load[i] & ~issued_q[i] &
                         entry_addr_valid[i] & ~blocked;
        end
    end

    lsq_age_picker #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)) u_pick_store (
        .req      (st_cand),
        .head_ptr (head_ptr),
        .found    (st_found),
        .idx      (st_idx)
    );

    lsq_age_picker #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W)) u_pick_load (
        .req      (ld_elig),
        .head_ptr (head_ptr),
        .found    (ld_found),
        .idx      (ld_idx)
    );

    // Only the oldest unissued store may go, and only once fully ready.
    assign st_ok  = st_found & entry_addr_valid[st_idx] & entry_data_valid[st_idx] &
                    entry_committed[st_idx];
    assign st_age = st_idx - head_ptr;
    assign ld_age = ld_idx - head_ptr;

    always_comb begin
        sel_found = 1'b0;
        sel_we    = 1'b0;
        sel_idx   = '0;
        if (st_ok && (!ld_found || st_age <= ld_age)) begin
            sel_found = 1'b1;
            sel_we    = 1'b1;
            sel_idx   = st_idx;
        end else if (ld_found) begin
            sel_found = 1'b1;
            sel_idx   = ld_idx;
        end
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        ld_fire = 1'b0;
        st_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flush && sel_found) begin
                    take    = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (we_q) begin
                    if (mem_gnt) begin
                        st_fire = 1'b1;
                        state_d = IDLE;
                    end
                end else if (flush) begin
                    state_d = mem_gnt ? DRAIN : IDLE;
                end else if (mem_gnt) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // Flush with rvalid in the same cycle consumes the response here.
                if (mem_rvalid) begin
                    ld_fire = ~flush;
                    state_d = IDLE;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issued_d = issued_q;
        if (flush) begin
            issued_d = '0;
            if (state_q == REQ && we_q) issued_d[idx_q] = 1'b1;
        end
        if (take) issued_d[sel_idx] = 1'b1;
        issued_d = issued_d & entry_valid;

        st_cmpl_d = st_cmpl_q;
        if (st_fire) st_cmpl_d[idx_q] = 1'b1;
        st_cmpl_d = st_cmpl_d & entry_valid;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued_q       <= '0;
            st_cmpl_q      <= '0;
            idx_q          <= '0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            load_done      <= 1'b0;
            load_done_idx  <= '0;
            load_done_data <= '0;
            store_done     <= 1'b0;
            store_done_idx <= '0;
        end else begin
            issued_q   <= issued_d;
            st_cmpl_q  <= st_cmpl_d;
            load_done  <= ld_fire;
            store_done <= st_fire;
            if (take) begin
                idx_q   <= sel_idx;
                we_q    <= sel_we;
                addr_q  <= addr_arr[sel_idx];
                wdata_q <= sel_we ? data_arr[sel_idx] : '0;
            end
            if (ld_fire) begin
                load_done_idx  <= idx_q;
                load_done_data <= mem_rdata;
            end
            if (st_fire) store_done_idx <= idx_q;
        end
    end

    assign mem_req   = (state_q == REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsq_mem_scheduler.sv
// Scoreboarded bench for lsq_mem_scheduler: completions are queued when a
// transaction is set up and popped when load_done/store_done pulse.
module tb_lsq_mem_scheduler;
    import lsq_pkg::*;

    localparam int N  = 16;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [IW-1:0] head_ptr = '0;
    logic [N-1:0]  ev = '0, il = '0, av = '0, dv = '0, cm = '0;
    logic [AW-1:0] ea [N];
    logic [DW-1:0] ed [N];
    logic [N*AW-1:0] entry_addr;
    logic [N*DW-1:0] entry_data;
    logic          flush = 1'b0;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          load_done, store_done;
    logic [IW-1:0] load_done_idx, store_done_idx;
    logic [DW-1:0] load_done_data;

    typedef struct {
        bit       is_load;
        lsq_idx_t idx;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            entry_addr[i*AW +: AW] = ea[i];
            entry_data[i*DW +: DW] = ed[i];
        end
    end

    lsq_mem_scheduler #(.NUM_ENTRIES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk              (clk),
        .reset            (reset),
        .head_ptr         (head_ptr),
        .entry_valid      (ev),
        .entry_is_load    (il),
        .entry_addr_valid (av),
        .entry_data_valid (dv),
        .entry_committed  (cm),
        .entry_addr       (entry_addr),
        .entry_data       (entry_data),
        .flush            (flush),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_gnt          (mem_gnt),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .load_done        (load_done),
        .load_done_idx    (load_done_idx),
        .load_done_data   (load_done_data),
        .store_done       (store_done),
        .store_done_idx   (store_done_idx)
    );

    task automatic push_exp(input bit is_load, input int idx, input logic [DW-1:0] data);
        exp_t e;
        e.is_load = is_load;
        e.idx     = lsq_idx_t'(idx);
        e.data    = data;
        sb.push_back(e);
    endtask

    // Advance to the next falling edge and retire any completion against the scoreboard.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (load_done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_load_done idx=%0d data=%h", load_done_idx, load_done_data);
            end else begin
                e = sb.pop_front();
                if (!e.is_load || load_done_idx !== e.idx || load_done_data !== e.data) begin
                    errors++;
                    $display("FAIL load_done got idx=%0d data=%h, expected is_load=%0b idx=%0d data=%h",
                             load_done_idx, load_done_data, e.is_load, e.idx, e.data);
                end
            end
        end
        if (store_done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_store_done idx=%0d", store_done_idx);
            end else begin
                e = sb.pop_front();
                if (e.is_load || store_done_idx !== e.idx) begin
                    errors++;
                    $display("FAIL store_done got idx=%0d, expected is_load=%0b idx=%0d",
                             store_done_idx, e.is_load, e.idx);
                end
            end
        end
    endtask

    task automatic wait_req(input string name, input int max);
        int n = 0;
        while (mem_req !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL %s mem_req timeout after %0d cycles", name, n);
        end
    endtask

    task automatic set_entry(input int i, input bit ld, input bit a_v, input bit d_v, input bit c,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        ev[i] = 1'b1; il[i] = ld; av[i] = a_v; dv[i] = d_v; cm[i] = c;
        ea[i] = a; ed[i] = d;
    endtask

    task automatic clear_entries();
        ev = '0; il = '0; av = '0; dv = '0; cm = '0;
        for (int i = 0; i < N; i++) begin
            ea[i] = '0;
            ed[i] = '0;
        end
    endtask

    // Grant the pending load now, return rdata `dly` cycles after the grant.
    task automatic respond(input logic [DW-1:0] d, input int dly);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        repeat (dly - 1) tick();
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        tick();
        mem_rvalid = 1'b0;
    endtask

    task automatic check_drained(input string name);
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s pending completions got=%0d expected=0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        clear_entries();
        repeat (2) tick();
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_we got req=%b we=%b expected 0/0", mem_req, mem_we);
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_addr_wdata got addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
        end
        checks++;
        if (load_done !== 1'b0 || store_done !== 1'b0 || load_done_idx !== '0 ||
            load_done_data !== '0 || store_done_idx !== '0) begin
            errors++;
            $display("FAIL reset_done got ld=%b st=%b expected 0", load_done, store_done);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_load();
        head_ptr = 4'd0;
        set_entry(3, 1, 1, 0, 0, 32'h100, 32'h0);
        push_exp(1, 3, 32'hDEADBEEF);
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL single_load_issue got req=%b we=%b addr=%h expected 1/0/00000100",
                     mem_req, mem_we, mem_addr);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL single_load_req_pulse got req=%b expected 0", mem_req);
        end
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (load_done !== 1'b1) begin
            errors++;
            $display("FAIL single_load_latency got load_done=%b expected 1", load_done);
        end
        ev[3] = 1'b0;
        check_drained("single_load");
    endtask

    task automatic test_ordering();
        clear_entries();
        head_ptr = 4'd14;
        set_entry(15, 0, 1, 1, 1, 32'h40, 32'h5555_0040);
        set_entry(1,  1, 1, 0, 0, 32'h80, 32'h0);
        push_exp(0, 15, 32'h0);
        push_exp(1, 1, 32'h600D_0001);
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h5555_0040) begin
            errors++;
            $display("FAIL order_store_first got req=%b we=%b addr=%h wdata=%h expected 1/1/00000040/55550040",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        ev[15] = 1'b0;
        wait_req("order_load", 5);
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h80) begin
            errors++;
            $display("FAIL order_load_second got we=%b addr=%h expected 0/00000080", mem_we, mem_addr);
        end
        respond(32'h600D_0001, 1);
        ev[1] = 1'b0;
        check_drained("ordering");
    endtask

    task automatic test_disambiguation();
        clear_entries();
        head_ptr = 4'd0;
        set_entry(2, 0, 0, 1, 0, 32'h0,   32'hAAAA_0002);
        set_entry(5, 1, 1, 0, 0, 32'h204, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL disamb_unknown_addr cycle=%0d got req=%b expected 0", k, mem_req);
            end
        end
        av[2] = 1'b1;
        ea[2] = 32'h200;
        push_exp(1, 5, 32'h1111_0005);
        wait_req("disamb_load", 4);
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h204) begin
            errors++;
            $display("FAIL disamb_diff_word got we=%b addr=%h expected 0/00000204", mem_we, mem_addr);
        end
        respond(32'h1111_0005, 1);
        ev[5] = 1'b0;
        set_entry(6, 1, 1, 0, 0, 32'h202, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL disamb_same_word cycle=%0d got req=%b expected 0", k, mem_req);
            end
        end
        cm[2] = 1'b1;
        push_exp(0, 2, 32'h0);
        push_exp(1, 6, 32'h2222_0006);
        wait_req("disamb_store", 4);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hAAAA_0002) begin
            errors++;
            $display("FAIL disamb_store got we=%b addr=%h wdata=%h expected 1/00000200/aaaa0002",
                     mem_we, mem_addr, mem_wdata);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        ev[2] = 1'b0;
        wait_req("disamb_blocked_load", 5);
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h202) begin
            errors++;
            $display("FAIL disamb_load_after_store got we=%b addr=%h expected 0/00000202", mem_we, mem_addr);
        end
        respond(32'h2222_0006, 2);
        ev[6] = 1'b0;
        check_drained("disambiguation");
    endtask

    task automatic test_backpressure();
        clear_entries();
        head_ptr = 4'd0;
        set_entry(0, 0, 1, 1, 1, 32'h300, 32'hCAFE_F00D);
        push_exp(0, 0, 32'h0);
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h300 || mem_wdata !== 32'hCAFE_F00D) begin
                errors++;
                $display("FAIL backpressure_hold cycle=%0d got req=%b we=%b addr=%h wdata=%h expected 1/1/00000300/cafef00d",
                         k, mem_req, mem_we, mem_addr, mem_wdata);
            end
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        checks++;
        if (store_done !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_done got store_done=%b req=%b expected 1/0", store_done, mem_req);
        end
        ev[0] = 1'b0;
        check_drained("backpressure");
    endtask

    task automatic test_flush();
        clear_entries();
        head_ptr = 4'd0;
        set_entry(4, 1, 1, 0, 0, 32'h400, 32'h0);
        wait_req("flush_resp_issue", 3);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ev[4] = 1'b0;
        set_entry(5, 1, 1, 0, 0, 32'h500, 32'h0);
        tick();
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_drain_no_issue got req=%b expected 0", mem_req);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (load_done !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_drain_discard got load_done=%b req=%b expected 0/0", load_done, mem_req);
        end
        push_exp(1, 5, 32'h5555_0005);
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
            errors++;
            $display("FAIL flush_idle_after_drain got req=%b addr=%h expected 1/00000500", mem_req, mem_addr);
        end
        respond(32'h5555_0005, 1);
        ev[5] = 1'b0;

        set_entry(7, 0, 1, 1, 1, 32'h700, 32'h7777_0007);
        push_exp(0, 7, 32'h0);
        wait_req("flush_store_issue", 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h700) begin
            errors++;
            $display("FAIL flush_store_kept got req=%b we=%b addr=%h expected 1/1/00000700", mem_req, mem_we, mem_addr);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        checks++;
        if (store_done !== 1'b1) begin
            errors++;
            $display("FAIL flush_store_done got store_done=%b expected 1", store_done);
        end
        ev[7] = 1'b0;

        set_entry(8, 1, 1, 0, 0, 32'h800, 32'h0);
        wait_req("flush_load_req", 3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ev[8] = 1'b0;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_load_req_drop got req=%b expected 0", mem_req);
        end
        check_drained("flush");
    endtask

    task automatic test_async_reset();
        clear_entries();
        head_ptr = 4'd0;
        set_entry(9, 1, 1, 0, 0, 32'h900, 32'h0);
        wait_req("areset_issue", 3);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
            load_done !== 1'b0 || store_done !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate got req=%b addr=%h ld=%b st=%b expected all 0",
                     mem_req, mem_addr, load_done, store_done);
        end
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h777;
        reset      = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        checks++;
        if (load_done !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h900) begin
            errors++;
            $display("FAIL areset_reissue got load_done=%b req=%b addr=%h expected 0/1/00000900",
                     load_done, mem_req, mem_addr);
        end
        push_exp(1, 9, 32'hABCD_0009);
        respond(32'hABCD_0009, 1);
        ev[9] = 1'b0;
        check_drained("async_reset");
    endtask

    initial begin
        clear_entries();
        test_reset();
        test_single_load();
        test_ordering();
        test_disambiguation();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
